gray_ramp_tdc: RTL and testbench

//  Parametrised, multi-channel successor to the single Gray counter for ramp (single-slope) conversion.

---
 rtl/gray_ramp_tdc.sv | 152 +++++++++++++++
 tb/tb_gray_ramp_tdc.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_ramp_tdc.sv
// Multi-channel single-slope TDC: registered Gray count plus a first-trip code latch per comparator channel.
// Optional macro GRAY_TDC_CMP_SYNC_EN adds a 2-flop synchroniser on every comparator input.
module gray_ramp_tdc #(
  parameter int W       = 8,
  parameter int N_CH    = 4,
  parameter int MAX_CNT = 2**W-1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              convert,
  input  logic [N_CH-1:0]   cmp,
  output logic [W-1:0]      gray_out,
  output logic [N_CH*W-1:0] ch_data,
  output logic [N_CH-1:0]   ch_valid,
  output logic [N_CH-1:0]   ch_ovf,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_HOLD} state_t;

  localparam logic [W-1:0] LP_MAX      = W'(MAX_CNT);
  localparam logic [W-1:0] LP_GRAY_MAX = LP_MAX ^ (LP_MAX >> 1);

  state_t            r_state;
  state_t            w_stateNext;
  logic [W-1:0]      r_bin;
  logic [W-1:0]      r_gray;
  logic [W-1:0]      w_binInc;
  logic [N_CH*W-1:0] r_data;
  logic [N_CH-1:0]   r_valid;
  logic [N_CH-1:0]   r_ovf;
  logic [N_CH-1:0]   w_cmp;
  logic [N_CH-1:0]   w_trip;
  logic              w_allValid;
  logic              w_atMax;
  logic              w_keepCounting;

`ifdef GRAY_TDC_CMP_SYNC_EN
  logic [N_CH-1:0] r_sync1;
  logic [N_CH-1:0] r_sync2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= cmp;
      r_sync2 <= r_sync1;
    end
  end

  assign w_cmp = r_sync2;
`else
  assign w_cmp = cmp;
`endif

  // A channel trips only on its first comparator high; channels set this edge count toward completion.
  assign w_trip         = w_cmp & ~r_valid;
  assign w_allValid     = &(r_valid | w_trip);
  assign w_atMax        = (r_bin == LP_MAX);
  assign w_keepCounting = convert && !w_allValid && !w_atMax;
  assign w_binInc       = r_bin + W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      S_IDLE:  if (convert) w_stateNext = S_COUNT;
      S_COUNT: begin
        if (!convert)                   w_stateNext = S_IDLE;
        else if (w_allValid || w_atMax) w_stateNext = S_HOLD;
      end
      S_HOLD:  if (!convert) w_stateNext = S_IDLE;
      default: w_stateNext = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == S_COUNT);
    done = (r_state == S_HOLD);
  end

  // bin stops (no increment) on the exit edge, so HOLD shows the code of the last COUNT cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bin   <= '0;
      r_gray  <= '0;
      r_data  <= '0;
      r_valid <= '0;
      r_ovf   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_bin  <= '0;
          r_gray <= '0;
          if (convert) begin
            r_data  <= '0;
            r_valid <= '0;
            r_ovf   <= '0;
          end
        end
        S_COUNT: begin
          if (!convert) begin
            r_bin   <= '0;
            r_gray  <= '0;
            r_valid <= '0;
            r_ovf   <= '0;
          end else begin
            for (int i = 0; i < N_CH; i++) begin
              if (w_trip[i]) begin
                r_data[i*W +: W] <= r_gray;
                r_valid[i]       <= 1'b1;
              end else if (!r_valid[i] && w_atMax) begin
                r_data[i*W +: W] <= LP_GRAY_MAX;
                r_valid[i]       <= 1'b1;
                r_ovf[i]         <= 1'b1;
              end
            end
            if (w_keepCounting) begin
              r_bin  <= w_binInc;
              r_gray <= w_binInc ^ (w_binInc >> 1);
            end
          end
        end
        S_HOLD: begin
          if (!convert) begin
            r_bin  <= '0;
            r_gray <= '0;
          end
        end
        default: begin
          r_bin  <= '0;
          r_gray <= '0;
        end
      endcase
    end
  end

  assign gray_out = r_gray;
  assign ch_data  = r_data;
  assign ch_valid = r_valid;
  assign ch_ovf   = r_ovf;

endmodule

// File: tb/tb_gray_ramp_tdc.sv
// Self-checking bench for gray_ramp_tdc: hand-derived vector table, hand sequences and randomized trips.
// Expected results come from per-channel trip times (raw rise + synchroniser latency) and the Gray formula.
module tb_gray_ramp_tdc;

  localparam int W     = 8;
  localparam int N_CH  = 4;
  localparam int MAXC  = 255;
  localparam int NEVER = 9999;
`ifdef GRAY_TDC_CMP_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              convert = 1'b0;
  logic [N_CH-1:0]   cmp = '0;
  logic [W-1:0]      gray_out;
  logic [N_CH*W-1:0] ch_data;
  logic [N_CH-1:0]   ch_valid;
  logic [N_CH-1:0]   ch_ovf;
  logic              busy;
  logic              done;

  int checks = 0;
  int failures = 0;
  int curRise [N_CH];

  typedef struct packed {
    logic [N_CH-1:0][15:0] rise;
    logic [N_CH*W-1:0]     data;
    logic [N_CH-1:0]       ovf;
    logic [15:0]           endCyc;
  } vec_t;

  vec_t vecs [4];

  gray_ramp_tdc #(.W(W), .N_CH(N_CH), .MAX_CNT(MAXC)) dut (
    .clk(clk), .reset_n(reset_n), .convert(convert), .cmp(cmp),
    .gray_out(gray_out), .ch_data(ch_data), .ch_valid(ch_valid),
    .ch_ovf(ch_ovf), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] grayOf(input int v);
    logic [W-1:0] b;
    b = v[W-1:0];
    return b ^ (b >> 1);
  endfunction

  function automatic vec_t mkVec(input int r0, input int r1, input int r2, input int r3,
                                 input logic [N_CH*W-1:0] d, input logic [N_CH-1:0] o, input int e);
    vec_t v;
    v.rise[0] = 16'(r0);
    v.rise[1] = 16'(r1);
    v.rise[2] = 16'(r2);
    v.rise[3] = 16'(r3);
    v.data    = d;
    v.ovf     = o;
    v.endCyc  = 16'(e);
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Raw comparator for COUNT cycle k: low before the rise, high at the rise, random chatter afterwards.
  task automatic applyStimulus(input int k);
    for (int c = 0; c < N_CH; c++) begin
      if (k < curRise[c])       cmp[c] = 1'b0;
      else if (k == curRise[c]) cmp[c] = 1'b1;
      else                      cmp[c] = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic computeExpected(output logic [N_CH*W-1:0] d, output logic [N_CH-1:0] o, output int e);
    int eff;
    int maxEff;
    maxEff = 0;
    for (int c = 0; c < N_CH; c++) begin
      eff = (curRise[c] == NEVER) ? NEVER : curRise[c] + LAT;
      d[c*W +: W] = grayOf(eff > MAXC ? MAXC : eff);
      o[c] = (eff > MAXC);
      if (eff > maxEff) maxEff = eff;
    end
    e = (maxEff > MAXC) ? MAXC : maxEff;
  endtask

  task automatic runConversion(input string tag, input logic [N_CH*W-1:0] expData,
                               input logic [N_CH-1:0] expOvf, input int expEnd, input bit sweep);
    logic [W-1:0] prevGray;
    prevGray = '0;
    convert = 1'b1;
    cmp = '0;
    nextCycle();
    for (int k = 0; k <= expEnd; k++) begin
      checkOutput({tag, " busy"}, 32'(busy), 32'd1);
      checkOutput({tag, " gray"}, 32'(gray_out), 32'(grayOf(k)));
      if (sweep && k > 0)
        checkOutput({tag, " gray1bit"}, 32'($countones(gray_out ^ prevGray)), 32'd1);
      prevGray = gray_out;
      applyStimulus(k);
      nextCycle();
    end
    checkOutput({tag, " done"}, 32'(done), 32'd1);
    checkOutput({tag, " busyHold"}, 32'(busy), 32'd0);
    checkOutput({tag, " grayHold"}, 32'(gray_out), 32'(grayOf(expEnd)));
    checkOutput({tag, " data"}, 32'(ch_data), 32'(expData));
    checkOutput({tag, " valid"}, 32'(ch_valid), 32'hF);
    checkOutput({tag, " ovf"}, 32'(ch_ovf), 32'(expOvf));
    for (int h = 0; h < 3; h++) begin
      cmp = N_CH'($urandom);
      nextCycle();
      checkOutput({tag, " dataHeld"}, 32'(ch_data), 32'(expData));
      checkOutput({tag, " grayFrozen"}, 32'(gray_out), 32'(grayOf(expEnd)));
      checkOutput({tag, " doneHeld"}, 32'(done), 32'd1);
    end
    convert = 1'b0;
    cmp = '0;
    nextCycle();
    checkOutput({tag, " doneDrop"}, 32'(done), 32'd0);
    checkOutput({tag, " grayIdle"}, 32'(gray_out), 32'd0);
    checkOutput({tag, " dataKept"}, 32'(ch_data), 32'(expData));
    checkOutput({tag, " validKept"}, 32'(ch_valid), 32'hF);
    checkOutput({tag, " ovfKept"}, 32'(ch_ovf), 32'(expOvf));
    nextCycle();
  endtask

  initial begin
    logic [N_CH*W-1:0] d;
    logic [N_CH-1:0]   o;
    int                e;

`ifdef GRAY_TDC_CMP_SYNC_EN
    vecs[0] = mkVec(5, 10, 10, 10, 32'h0A0A0A04, 4'b0000, 12);
    vecs[1] = mkVec(0, 0, 0, 0, 32'h03030303, 4'b0000, 2);
    vecs[2] = mkVec(253, NEVER, 1, 0, 32'h03028080, 4'b0010, 255);
    vecs[3] = mkVec(254, 5, 5, 5, 32'h04040480, 4'b0001, 255);
`else
    vecs[0] = mkVec(5, 20, 20, 20, 32'h1E1E1E07, 4'b0000, 20);
    vecs[1] = mkVec(3, 0, 9, 255, 32'h800D0002, 4'b0000, 255);
    vecs[2] = mkVec(100, NEVER, 0, 254, 32'h81008056, 4'b0010, 255);
    vecs[3] = mkVec(0, 0, 0, 0, 32'h00000000, 4'b0000, 0);
`endif

    #2;
    checkOutput("rst gray", 32'(gray_out), 32'd0);
    checkOutput("rst busy", 32'(busy), 32'd0);
    checkOutput("rst done", 32'(done), 32'd0);
    checkOutput("rst data", 32'(ch_data), 32'd0);
    checkOutput("rst valid", 32'(ch_valid), 32'd0);
    checkOutput("rst ovf", 32'(ch_ovf), 32'd0);
    #20 reset_n = 1'b1;
    nextCycle();
    nextCycle();

    for (int v = 0; v < 4; v++) begin
      for (int c = 0; c < N_CH; c++)
        curRise[c] = (vecs[v].rise[c] >= 16'(NEVER)) ? NEVER : int'(vecs[v].rise[c]);
      runConversion($sformatf("vec%0d", v), vecs[v].data, vecs[v].ovf, int'(vecs[v].endCyc), 1'b0);
    end

    // Full sweep with no trips: every step one bit, timeout everywhere.
    curRise = '{NEVER, NEVER, NEVER, NEVER};
    runConversion("sweep", {N_CH{8'h80}}, 4'hF, MAXC, 1'b1);

    // Asynchronous reset in the middle of a conversion at bin=37.
    curRise = '{3, NEVER, NEVER, NEVER};
    convert = 1'b1;
    nextCycle();
    for (int k = 0; k < 37; k++) begin
      applyStimulus(k);
      nextCycle();
    end
    checkOutput("midrst gray37", 32'(gray_out), 32'(grayOf(37)));
    checkOutput("midrst valid", 32'(ch_valid), 32'h1);
    reset_n = 1'b0;
    #1;
    checkOutput("midrst gray", 32'(gray_out), 32'd0);
    checkOutput("midrst busy", 32'(busy), 32'd0);
    checkOutput("midrst data", 32'(ch_data), 32'd0);
    checkOutput("midrst valid0", 32'(ch_valid), 32'd0);
    checkOutput("midrst ovf", 32'(ch_ovf), 32'd0);
    convert = 1'b0;
    cmp = '0;
    #1 reset_n = 1'b1;
    nextCycle();
    checkOutput("postrst busy", 32'(busy), 32'd0);
    checkOutput("postrst done", 32'(done), 32'd0);
    nextCycle();

    // Abort at bin=10; the following conversion must restart from zero.
    curRise = '{2, NEVER, NEVER, NEVER};
    convert = 1'b1;
    nextCycle();
    for (int k = 0; k < 10; k++) begin
      applyStimulus(k);
      nextCycle();
    end
    checkOutput("abort gray10", 32'(gray_out), 32'(grayOf(10)));
    checkOutput("abort validPre", 32'(ch_valid), 32'(LAT == 0 ? 1 : 1));
    convert = 1'b0;
    cmp = '0;
    nextCycle();
    checkOutput("abort busy", 32'(busy), 32'd0);
    checkOutput("abort done", 32'(done), 32'd0);
    checkOutput("abort valid", 32'(ch_valid), 32'd0);
    checkOutput("abort ovf", 32'(ch_ovf), 32'd0);
    checkOutput("abort gray", 32'(gray_out), 32'd0);
    nextCycle();
    for (int c = 0; c < N_CH; c++)
      curRise[c] = int'(vecs[0].rise[c]);
    runConversion("restart", vecs[0].data, vecs[0].ovf, int'(vecs[0].endCyc), 1'b0);

    for (int r = 0; r < 20; r++) begin
      for (int c = 0; c < N_CH; c++)
        curRise[c] = ($urandom_range(0, 3) == 0) ? NEVER : int'($urandom_range(0, 270));
      computeExpected(d, o, e);
      runConversion($sformatf("rand%0d", r), d, o, e, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    failures++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
